npu_sched_controller: RTL and testbench

- Top-level sequencer for the NPU compute engine.
- Accepts a configuration stream (header plus schedule words) and loads the schedule words into the scheduler's circular buffer.
- Starts an invocation when the input FIFO holds a full operand set and the output FIFO has room for all results.
- During an invocation, drives the scheduler's compute-state line for exactly one schedule pass, waits for pipeline drain, then signals completion.

---
 rtl/npu_sched_controller.sv | 161 ++++++++++++++++
 tb/tb_npu_sched_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_sched_controller.sv
// NPU compute-engine sequencer: loads the schedule buffer from a config stream,
// then runs one schedule pass per invocation and waits for the pipeline to drain.
module npu_sched_controller #(
    parameter int SCHED_DEPTH = 64,
    parameter int CNT_W       = 6,
    parameter int DRAIN_CYC   = 4
) (
    input  logic             CLK,
    input  logic             npu_rst,
    input  logic             npu_cfg_start,
    input  logic             npu_cfg_valid,
    input  logic [15:0]      npu_cfg_din,
    output logic             npu_cfg_ready,
    output logic             npu_sched_buf_rst,
    output logic             npu_sched_write_en,
    output logic [15:0]      npu_sched_din,
    input  logic [CNT_W-1:0] npu_in_fifo_count,
    input  logic [CNT_W-1:0] npu_out_fifo_free,
    output logic             npu_state_compute,
    output logic             npu_invoke_done,
    output logic             npu_busy,
    output logic             npu_cfg_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG_HDR, S_CFG_LOAD, S_READY, S_COMPUTE, S_DRAIN
    } state_e;

    localparam logic [8:0] DEPTH_MAX  = 9'(SCHED_DEPTH);
    localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYC);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] len_q, len_d;
    logic [3:0] ni_q, ni_d;
    logic [3:0] no_q, no_d;
    logic       pend_q, pend_d;
    logic       err_q, err_d;

    logic [7:0] hdr_len;
    logic       hdr_bad;
    logic       fifo_ok;

    assign hdr_len = npu_cfg_din[7:0];
    assign hdr_bad = (hdr_len == 8'd0) || ({1'b0, hdr_len} > DEPTH_MAX);
    assign fifo_ok = (npu_in_fifo_count >= CNT_W'(ni_q)) &&
                     (npu_out_fifo_free >= CNT_W'(no_q));

    always_ff @(posedge CLK or posedge npu_rst) begin
        if (npu_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            ni_q    <= '0;
            no_q    <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ni_q    <= ni_d;
            no_q    <= no_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        len_d              = len_q;
        ni_d               = ni_q;
        no_d               = no_q;
        pend_d             = pend_q;
        err_d              = err_q;
        npu_cfg_ready      = 1'b0;
        npu_sched_buf_rst  = 1'b0;
        npu_sched_write_en = 1'b0;
        npu_sched_din      = '0;
        npu_state_compute  = 1'b0;
        npu_invoke_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (npu_cfg_start) begin
                    npu_sched_buf_rst = 1'b1;
                    state_d           = S_CFG_HDR;
                end
            end
            S_CFG_HDR: begin
                npu_cfg_ready = 1'b1;
                if (npu_cfg_start) pend_d = 1'b1;
                if (npu_cfg_valid) begin
                    if (hdr_bad) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b0;
                        len_d   = hdr_len;
                        ni_d    = npu_cfg_din[11:8];
                        no_d    = npu_cfg_din[15:12];
                        cnt_d   = hdr_len;
                        state_d = S_CFG_LOAD;
                    end
                end
            end
            S_CFG_LOAD: begin
                npu_cfg_ready = 1'b1;
                if (npu_cfg_start) pend_d = 1'b1;
                if (npu_cfg_valid) begin
                    npu_sched_write_en = 1'b1;
                    npu_sched_din      = npu_cfg_din;
                    cnt_d              = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = S_READY;
                end
            end
            S_READY: begin
                // A queued or fresh reconfiguration beats a ready invocation.
                if (pend_q || npu_cfg_start) begin
                    npu_sched_buf_rst = 1'b1;
                    pend_d            = 1'b0;
                    state_d           = S_CFG_HDR;
                end else if (fifo_ok) begin
                    cnt_d   = len_q;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                npu_state_compute = 1'b1;
                if (npu_cfg_start) pend_d = 1'b1;
                if (cnt_q == 8'd1) begin
                    if (DRAIN_CYC == 0) begin
                        npu_invoke_done = 1'b1;
                        state_d         = S_READY;
                    end else begin
                        cnt_d   = DRAIN_INIT;
                        state_d = S_DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DRAIN: begin
                if (npu_cfg_start) pend_d = 1'b1;
                if (cnt_q == 8'd1) begin
                    npu_invoke_done = 1'b1;
                    state_d         = S_READY;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign npu_busy      = (state_q == S_CFG_HDR) || (state_q == S_CFG_LOAD) ||
                           (state_q == S_COMPUTE) || (state_q == S_DRAIN);
    assign npu_cfg_error = err_q;

endmodule

// File: tb/tb_npu_sched_controller.sv
// Scoreboard bench for npu_sched_controller: stimulus pushes expected schedule
// writes and compute bursts; a negedge monitor pops and compares them.
module tb_npu_sched_controller;

    localparam int SCHED_DEPTH = 64;
    localparam int CNT_W       = 6;
    localparam int DRAIN_CYC   = 4;

    logic             CLK = 1'b0;
    logic             npu_rst = 1'b0;
    logic             npu_cfg_start = 1'b0;
    logic             npu_cfg_valid = 1'b0;
    logic [15:0]      npu_cfg_din = '0;
    logic             npu_cfg_ready;
    logic             npu_sched_buf_rst;
    logic             npu_sched_write_en;
    logic [15:0]      npu_sched_din;
    logic [CNT_W-1:0] npu_in_fifo_count = '0;
    logic [CNT_W-1:0] npu_out_fifo_free = '0;
    logic             npu_state_compute;
    logic             npu_invoke_done;
    logic             npu_busy;
    logic             npu_cfg_error;

    npu_sched_controller #(
        .SCHED_DEPTH(SCHED_DEPTH), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .CLK(CLK), .npu_rst(npu_rst),
        .npu_cfg_start(npu_cfg_start), .npu_cfg_valid(npu_cfg_valid),
        .npu_cfg_din(npu_cfg_din), .npu_cfg_ready(npu_cfg_ready),
        .npu_sched_buf_rst(npu_sched_buf_rst), .npu_sched_write_en(npu_sched_write_en),
        .npu_sched_din(npu_sched_din),
        .npu_in_fifo_count(npu_in_fifo_count), .npu_out_fifo_free(npu_out_fifo_free),
        .npu_state_compute(npu_state_compute), .npu_invoke_done(npu_invoke_done),
        .npu_busy(npu_busy), .npu_cfg_error(npu_cfg_error)
    );

    always #5 CLK = ~CLK;

    typedef struct { int len; int gap; } burst_t;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] exp_wr[$];
    burst_t      exp_burst[$];
    int          exp_done   = 0;
    int          exp_bufrst = 0;

    // reference model of the loaded configuration
    bit mdl_cfg = 0;
    int mdl_len = 0, mdl_ni = 0, mdl_no = 0;

    // monitor state
    int     done_cnt = 0, bufrst_cnt = 0;
    bit     in_burst = 0;
    int     run = 0, since = 1000;
    burst_t cur;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    always @(negedge CLK) begin
        if (npu_rst) begin
            in_burst   = 0;
            since      = 1000;
            done_cnt   = 0;
            bufrst_cnt = 0;
        end else begin
            if (npu_sched_write_en) begin
                if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
                else check("sched_din", int'(npu_sched_din), int'(exp_wr.pop_front()));
            end
            if (npu_sched_buf_rst) bufrst_cnt++;
            if (npu_state_compute) begin
                if (!in_burst) begin
                    in_burst = 1;
                    run      = 0;
                    if (exp_burst.size() == 0) begin
                        check("unexpected_compute", 1, 0);
                        cur.len = -1;
                        cur.gap = -1;
                    end else begin
                        cur = exp_burst.pop_front();
                        if (cur.gap >= 0) check("pass_gap", since, cur.gap);
                    end
                end
                run++;
                since = 0;
            end else begin
                if (in_burst) begin
                    in_burst = 0;
                    if (cur.len >= 0) check("compute_len", run, cur.len);
                end
                since++;
            end
            if (npu_invoke_done) begin
                done_cnt++;
                check("done_latency", since, DRAIN_CYC);
            end
        end
    end

    // Tasks start and end just after a rising edge.
    task automatic send_word(input logic [15:0] w);
        int gap;
        int t;
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge CLK); #1; end
        npu_cfg_valid = 1'b1;
        npu_cfg_din   = w;
        t = 0;
        @(negedge CLK);
        while (!npu_cfg_ready && t < 10) begin @(negedge CLK); t++; end
        if (!npu_cfg_ready) fail_now("cfg_ready_wait");
        @(posedge CLK); #1;
        npu_cfg_valid = 1'b0;
        npu_cfg_din   = $urandom;
    endtask

    task automatic do_config(input logic [15:0] hdr, input bit start, input int wbase);
        int          l;
        logic [15:0] w;
        l = int'(hdr[7:0]);
        if (start) begin
            npu_cfg_start = 1'b1;
            exp_bufrst++;
            @(posedge CLK); #1;
            npu_cfg_start = 1'b0;
        end
        mdl_cfg = 0;
        send_word(hdr);
        @(negedge CLK);
        if (l == 0 || l > SCHED_DEPTH) begin
            check("cfg_error_set", int'(npu_cfg_error), 1);
            check("bad_hdr_idle_busy", int'(npu_busy), 0);
            check("bad_hdr_idle_ready", int'(npu_cfg_ready), 0);
            @(posedge CLK); #1;
        end else begin
            mdl_len = l;
            mdl_ni  = int'(hdr[11:8]);
            mdl_no  = int'(hdr[15:12]);
            check("cfg_error_clr", int'(npu_cfg_error), 0);
            check("load_busy", int'(npu_busy), 1);
            @(posedge CLK); #1;
            for (int i = 0; i < l; i++) begin
                w = (wbase != 0) ? 16'(wbase * (i + 1)) : 16'($urandom);
                exp_wr.push_back(w);
                send_word(w);
            end
            @(negedge CLK);
            check("ready_busy", int'(npu_busy), 0);
            check("ready_cfg_ready", int'(npu_cfg_ready), 0);
            mdl_cfg = 1;
            @(posedge CLK); #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge CLK);
        while (npu_busy && t < 400) begin @(negedge CLK); t++; end
        if (npu_busy) fail_now(name);
        @(posedge CLK); #1;
    endtask

    task automatic run_pass(input int ic, input int of);
        bit     go;
        burst_t b;
        go = mdl_cfg && (ic >= mdl_ni) && (of >= mdl_no);
        if (go) begin
            b.len = mdl_len;
            b.gap = -1;
            exp_burst.push_back(b);
            exp_done++;
        end
        npu_in_fifo_count = CNT_W'(ic);
        npu_out_fifo_free = CNT_W'(of);
        @(posedge CLK); #1;
        npu_in_fifo_count = '0;
        npu_out_fifo_free = '0;
        @(negedge CLK);
        check("busy_after_decision", int'(npu_busy), int'(go));
        @(posedge CLK); #1;
        wait_idle("pass_finish");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        burst_t b;
        int     t, seen;
        logic [15:0] hdr;
        int     r, l;

        // reset state
        #2 npu_rst = 1'b1;
        #1;
        check("rst_compute", int'(npu_state_compute), 0);
        check("rst_busy", int'(npu_busy), 0);
        check("rst_done", int'(npu_invoke_done), 0);
        check("rst_err", int'(npu_cfg_error), 0);
        check("rst_ready", int'(npu_cfg_ready), 0);
        check("rst_write", int'(npu_sched_write_en), 0);
        check("rst_bufrst", int'(npu_sched_buf_rst), 0);
        repeat (2) @(posedge CLK);
        #1 npu_rst = 1'b0;

        // first configuration with fixed words 0x11, 0x22, 0x33
        do_config(16'h2103, 1, 'h11);
        check("bufrst_count_cfg1", bufrst_cnt, exp_bufrst);

        // words offered while READY are ignored
        npu_cfg_valid = 1'b1;
        npu_cfg_din   = 16'hBEEF;
        @(negedge CLK);
        check("ready_rejects_word", int'(npu_cfg_ready), 0);
        @(posedge CLK); #1;
        npu_cfg_valid = 1'b0;

        run_pass(0, 5);
        run_pass(1, 5);

        // async reset in the middle of a pass
        npu_in_fifo_count = 1;
        npu_out_fifo_free = 5;
        b.len = 3; b.gap = -1;
        exp_burst.push_back(b);
        exp_done++;
        @(posedge CLK); #1;
        npu_in_fifo_count = '0;
        npu_out_fifo_free = '0;
        @(negedge CLK);
        check("compute_started", int'(npu_state_compute), 1);
        @(posedge CLK); #3;
        npu_rst = 1'b1;
        exp_wr.delete();
        exp_burst.delete();
        exp_done = 0;
        exp_bufrst = 0;
        mdl_cfg = 0;
        #1;
        check("midrst_compute", int'(npu_state_compute), 0);
        check("midrst_busy", int'(npu_busy), 0);
        check("midrst_done", int'(npu_invoke_done), 0);
        check("midrst_err", int'(npu_cfg_error), 0);
        @(posedge CLK); #1;
        npu_rst = 1'b0;
        run_pass(15, 15);

        // rejected headers, then a good one clears the error
        do_config(16'h0000, 1, 0);
        do_config(16'h2141, 1, 0);
        run_pass(15, 15);
        do_config(16'h2103, 1, 'h11);

        // reconfiguration request during a pass; config beats invocation
        npu_in_fifo_count = 5;
        npu_out_fifo_free = 30;
        b.len = 3; b.gap = -1;
        exp_burst.push_back(b);
        exp_done++;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        npu_cfg_start = 1'b1;
        exp_bufrst++;
        @(posedge CLK); #1;
        npu_cfg_start = 1'b0;
        t = 0;
        @(negedge CLK);
        while (!npu_cfg_ready && t < 30) begin @(negedge CLK); t++; end
        if (!npu_cfg_ready) fail_now("pending_cfg_wait");
        check("pending_bufrst", bufrst_cnt, exp_bufrst);
        check("pending_done", done_cnt, exp_done);
        @(posedge CLK); #1;
        npu_in_fifo_count = '0;
        npu_out_fifo_free = '0;
        do_config(16'h2103, 0, 'h11);

        // continuous FIFO condition: three back-to-back passes
        b.len = 3; b.gap = -1;
        exp_burst.push_back(b);
        b.gap = DRAIN_CYC + 1;
        exp_burst.push_back(b);
        exp_burst.push_back(b);
        exp_done += 3;
        npu_in_fifo_count = 5;
        npu_out_fifo_free = 30;
        seen = 0;
        t = 0;
        while (seen < 3 && t < 200) begin
            @(negedge CLK);
            if (npu_invoke_done) seen++;
            t++;
        end
        if (seen < 3) fail_now("continuous_done_wait");
        @(posedge CLK); #1;
        npu_in_fifo_count = '0;
        npu_out_fifo_free = '0;
        wait_idle("continuous_finish");
        check("continuous_done_count", done_cnt, exp_done);

        // randomized configurations and invocations
        for (int it = 0; it < 8; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      l = 0;
            else if (r == 1) l = $urandom_range(65, 255);
            else if (r == 2) l = 64;
            else             l = $urandom_range(1, 8);
            hdr = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), 8'(l)};
            do_config(hdr, 1, 0);
            for (int p = 0; p < 4; p++)
                run_pass($urandom_range(0, 20), $urandom_range(0, 20));
        end

        repeat (3) @(posedge CLK);
        #1;
        check("final_wr_queue", exp_wr.size(), 0);
        check("final_burst_queue", exp_burst.size(), 0);
        check("final_done_count", done_cnt, exp_done);
        check("final_bufrst_count", bufrst_cnt, exp_bufrst);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
